step_sequencer: RTL and testbench

- Downstream consumer of the quarter-note beat enable produced by the bpm generator.
- Holds a programmable pattern of STEPS steps. Each step has a note code and an active bit.
- Advances one step per beat pulse while playing.
- Emits the current note, a fixed-length gate and a one-cycle note_on strobe to the tone/audio stage.

---
 rtl/step_sequencer.sv | 139 +++++++++++++
 tb/tb_step_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - beat-driven pattern step sequencer with gated note output
module step_sequencer #(
  parameter int STEPS    = 16,
  parameter int NOTE_W   = 4,
  parameter int GATE_LEN = 5000000,
  parameter int GATE_W   = 23
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              play,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_active,
  output logic [3:0]        step_idx,
  output logic [NOTE_W-1:0] note,
  output logic              gate,
  output logic              note_on
);

  localparam int PTR_W = $clog2(STEPS);
  localparam logic [PTR_W-1:0]  LAST_STEP = PTR_W'(STEPS - 1);
  localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_LEN - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [NOTE_W-1:0] pat_note [STEPS];
  logic [STEPS-1:0]  pat_active;

  logic [PTR_W-1:0]  ptr, ptr_nxt;
  logic [GATE_W-1:0] gate_cnt, gate_cnt_nxt;
  logic [3:0]        step_idx_nxt;
  logic [NOTE_W-1:0] note_nxt;
  logic              gate_nxt;
  logic              note_on_nxt;

  logic              wr_hit;
  logic [PTR_W-1:0]  wr_idx;
  logic [NOTE_W-1:0] cur_note;
  logic              cur_active;

  // Addresses beyond the pattern length are silently dropped.
  assign wr_hit     = wr_en && (int'(wr_addr) < STEPS);
  assign wr_idx     = wr_addr[PTR_W-1:0];
  assign cur_note   = pat_note[ptr];
  assign cur_active = pat_active[ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STEPS; i++) begin
        pat_note[i] <= '0;
      end
      pat_active <= '0;
    end else if (wr_hit) begin
      pat_note[wr_idx]   <= wr_note;
      pat_active[wr_idx] <= wr_active;
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    gate_cnt_nxt = gate_cnt;
    step_idx_nxt = step_idx;
    note_nxt     = note;
    gate_nxt     = gate;
    note_on_nxt  = 1'b0;

    case (state)
      IDLE: begin
        ptr_nxt      = '0;
        gate_nxt     = 1'b0;
        gate_cnt_nxt = '0;
        if (play) begin
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (!play) begin
          // Stop wins over a coincident beat; note and step_idx keep their last values.
          state_nxt    = IDLE;
          ptr_nxt      = '0;
          gate_nxt     = 1'b0;
          gate_cnt_nxt = '0;
        end else if (beat) begin
          step_idx_nxt = 4'(ptr);
          ptr_nxt      = (ptr == LAST_STEP) ? '0 : ptr + 1'b1;
          if (cur_active) begin
            note_nxt     = cur_note;
            note_on_nxt  = 1'b1;
            gate_nxt     = 1'b1;
            gate_cnt_nxt = GATE_LOAD;
          end else begin
            gate_nxt     = 1'b0;
            gate_cnt_nxt = '0;
          end
        end else if (gate) begin
          if (gate_cnt != '0) begin
            gate_cnt_nxt = gate_cnt - 1'b1;
          end else begin
            gate_nxt = 1'b0;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      gate_cnt <= '0;
      step_idx <= '0;
      note     <= '0;
      gate     <= 1'b0;
      note_on  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      gate_cnt <= gate_cnt_nxt;
      step_idx <= step_idx_nxt;
      note     <= note_nxt;
      gate     <= gate_nxt;
      note_on  <= note_on_nxt;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// tb/tb_step_sequencer.sv - randomized and directed check of step_sequencer against a reference model
module tb_step_sequencer;

  localparam int STEPS    = 8;
  localparam int NOTE_W   = 4;
  localparam int GATE_LEN = 5;
  localparam int GATE_W   = 3;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              beat = 1'b0;
  logic              play = 1'b0;
  logic              wr_en = 1'b0;
  logic [3:0]        wr_addr = '0;
  logic [NOTE_W-1:0] wr_note = '0;
  logic              wr_active = 1'b0;
  logic [3:0]        step_idx;
  logic [NOTE_W-1:0] note;
  logic              gate;
  logic              note_on;

  step_sequencer #(
    .STEPS   (STEPS),
    .NOTE_W  (NOTE_W),
    .GATE_LEN(GATE_LEN),
    .GATE_W  (GATE_W)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .beat     (beat),
    .play     (play),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_note  (wr_note),
    .wr_active(wr_active),
    .step_idx (step_idx),
    .note     (note),
    .gate     (gate),
    .note_on  (note_on)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: pattern as plain arrays, gate as "cycles of sound left".
  int m_pat_note [16];
  int m_pat_act  [16];
  bit m_running;
  int m_pos;
  int m_step;
  int m_note;
  bit m_on;
  int m_gate_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_pat_note[i] = 0;
      m_pat_act[i]  = 0;
    end
    m_running   = 1'b0;
    m_pos       = 0;
    m_step      = 0;
    m_note      = 0;
    m_on        = 1'b0;
    m_gate_left = 0;
  endtask

  task automatic model_step(input bit b, input bit p, input bit we, input int wa,
                            input int wn, input bit wact);
    if (!m_running) begin
      m_running   = p;
      m_pos       = 0;
      m_on        = 1'b0;
      m_gate_left = 0;
    end else if (!p) begin
      m_running   = 1'b0;
      m_pos       = 0;
      m_on        = 1'b0;
      m_gate_left = 0;
    end else if (b) begin
      m_step = m_pos;
      if (m_pat_act[m_pos] != 0) begin
        m_note      = m_pat_note[m_pos];
        m_on        = 1'b1;
        m_gate_left = GATE_LEN;
      end else begin
        m_on        = 1'b0;
        m_gate_left = 0;
      end
      m_pos = (m_pos + 1) % STEPS;
    end else begin
      m_on = 1'b0;
      if (m_gate_left > 0) m_gate_left--;
    end
    // The write lands after the beat has read the old entry.
    if (we && wa < STEPS) begin
      m_pat_note[wa] = wn;
      m_pat_act[wa]  = int'(wact);
    end
  endtask

  task automatic compare_outputs(input string ph);
    check({ph, ".step_idx"}, 32'(step_idx), 32'(m_step));
    check({ph, ".note"},     32'(note),     32'(m_note));
    check({ph, ".gate"},     32'(gate),     32'(m_gate_left > 0));
    check({ph, ".note_on"},  32'(note_on),  32'(m_on));
  endtask

  task automatic tick(input bit b, input bit p, input bit we, input int wa,
                      input int wn, input bit wact, input string ph);
    beat      = b;
    play      = p;
    wr_en     = we;
    wr_addr   = 4'(wa);
    wr_note   = NOTE_W'(wn);
    wr_active = wact;
    @(posedge clk);
    model_step(b, p, we, wa, wn, wact);
    #1;
    compare_outputs(ph);
  endtask

  task automatic idle_cycles(input int n, input string ph);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, ph);
  endtask

  task automatic write_step(input int wa, input int wn, input bit wact, input bit p, input string ph);
    tick(1'b0, p, 1'b1, wa, wn, wact, ph);
  endtask

  task automatic beat_then_wait(input int gap, input string ph);
    tick(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, ph);
    for (int i = 1; i < gap; i++) tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, ph);
  endtask

  task automatic hold_reset(input int n, input string ph);
    beat  = 1'b0;
    play  = 1'b0;
    wr_en = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    compare_outputs(ph);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      compare_outputs(ph);
    end
    reset = 1'b1;
  endtask

  initial begin
    model_reset();
    hold_reset(3, "rst0");

    // Unwritten pattern: steps advance but nothing sounds.
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "blank");
    for (int i = 0; i < 4; i++) beat_then_wait(3, "blank");
    idle_cycles(2, "blank");

    // Active / rest / active with a long beat spacing.
    write_step(0, 5, 1'b1, 1'b0, "basic");
    write_step(1, 9, 1'b0, 1'b0, "basic");
    write_step(2, 10, 1'b1, 1'b0, "basic");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "basic");
    for (int i = 0; i < 3; i++) beat_then_wait(10, "basic");
    idle_cycles(2, "basic");

    // Retrigger shorter than the gate, then a rest cutting a sounding note.
    write_step(1, 3, 1'b1, 1'b0, "retrig");
    write_step(2, 11, 1'b0, 1'b0, "retrig");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "retrig");
    for (int i = 0; i < 3; i++) beat_then_wait(3, "retrig");
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "retrig");
    idle_cycles(2, "retrig");

    // Wrap with every step active, note = index.
    for (int s = 0; s < STEPS; s++) write_step(s, s, 1'b1, 1'b0, "wrap");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "wrap");
    for (int i = 0; i < STEPS + 1; i++) beat_then_wait(2, "wrap");

    // Stop on a beat cycle, then restart from step 0.
    for (int i = 0; i < 5; i++) beat_then_wait(2, "stop");
    tick(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, "stop");
    idle_cycles(2, "stop");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "stop");
    beat_then_wait(3, "stop");
    idle_cycles(1, "stop");

    // Write landing on the step that plays in the same cycle; out-of-range write.
    write_step(3, 2, 1'b1, 1'b0, "coll");
    write_step(11, 15, 1'b0, 1'b0, "coll");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "coll");
    for (int i = 0; i < 3; i++) beat_then_wait(2, "coll");
    tick(1'b1, 1'b1, 1'b1, 3, 7, 1'b1, "coll");
    tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, "coll");
    for (int i = 0; i < STEPS + 2; i++) beat_then_wait(2, "coll");
    idle_cycles(1, "coll");

    // Random traffic with a mid-run asynchronous reset.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) hold_reset(2, "rst1");
      tick($urandom_range(0, 3) == 0, $urandom_range(0, 59) != 0,
           $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
